// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a first-word-fall-through byte FIFO.
// Flags framing errors and bytes dropped on a full FIFO with one-cycle pulses.
module uart_rx_fifo #(
   parameter int CLK_HZ     = 50000000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               rxd,
   output logic [7:0]                         rx_data,
   output logic                               rx_valid,
   input  logic                               rx_ready,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
   output logic                               frame_err,
   output logic                               overrun
);
   localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int CW           = $clog2(CLKS_PER_BIT);
   localparam int AW           = $clog2(FIFO_DEPTH);
   localparam int NW           = $clog2(FIFO_DEPTH + 1);

   localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_BIT - 1);
   localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
   localparam logic [NW-1:0] FULL_COUNT = NW'(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [2:0]      bit_idx;
   logic [7:0]      shreg;
   logic            rxd_m;
   logic            rxd_s;

   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [NW-1:0]   count;

   logic            push;
   logic            pop;
   logic            full;
   logic            do_write;

   // The serial pin is asynchronous, so it passes through two flops that idle high.
   always_ff @(posedge clk) begin
      if (reset) begin
         rxd_m <= 1'b1;
         rxd_s <= 1'b1;
      end else begin
         rxd_m <= rxd;
         rxd_s <= rxd_m;
      end
   end

   // Receiver FSM; returning to IDLE mid-stop-bit allows gapless back-to-back frames.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (!rxd_s) state <= START;
            end
            START: begin
               if (cnt == HALF_LAST) begin
                  cnt <= '0;
                  if (!rxd_s) begin
                     state   <= DATA;
                     bit_idx <= '0;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (cnt == BIT_LAST) begin
                  cnt     <= '0;
                  shreg   <= {rxd_s, shreg[7:1]};
                  bit_idx <= bit_idx + 1'b1;
                  if (bit_idx == 3'd7) state <= STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STOP: begin
               if (cnt == BIT_LAST) begin
                  cnt <= '0;
                  if (rxd_s) begin
                     state <= IDLE;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= BREAK;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            BREAK: begin
               cnt <= '0;
               if (rxd_s) state <= IDLE;
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   assign push     = (state == STOP) && (cnt == BIT_LAST) && rxd_s;
   assign full     = (count == FULL_COUNT);
   assign pop      = rx_valid && rx_ready;
   // A simultaneous pop frees the slot, so a push into a full FIFO still succeeds.
   assign do_write = push && (!full || pop);

   always_ff @(posedge clk) begin
      if (do_write) mem[wr_ptr] <= shreg;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         overrun <= 1'b0;
      end else begin
         overrun <= push && full && !pop;
         if (do_write) wr_ptr <= wr_ptr + 1'b1;
         if (pop)      rd_ptr <= rd_ptr + 1'b1;
         if (do_write && !pop)      count <= count + 1'b1;
         else if (!do_write && pop) count <= count - 1'b1;
      end
   end

   assign rx_data    = mem[rd_ptr];
   assign rx_valid   = (count != '0);
   assign fifo_count = count;

endmodule
